// File: rtl/sky_xu_pkg.sv
// Shared XU pipeline definitions: NOP encoding, opcode field, fetch FSM states and
// the fetch buffer entry layout.
package sky_xu_pkg;

    // All-zero word decodes as r-type add r0, r0, r0.
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE  = 6'h00;
    localparam opcode_t OP_JUMP   = 6'h02;
    localparam opcode_t OP_BRANCH = 6'h04;
    localparam opcode_t OP_ADDI   = 6'h08;
    localparam opcode_t OP_LOAD   = 6'h23;
    localparam opcode_t OP_STORE  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    function automatic opcode_t opcode_of(input logic [31:0] insn);
        return insn[31:26];
    endfunction

endpackage

// File: rtl/sky_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and
// instruction memory (slave).
interface sky_fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );
endinterface

// File: rtl/sky_fetch_buffer.sv
// DEPTH-entry synchronous FIFO of {pc, insn} pairs with push, pop, clear and an
// occupancy count. DEPTH must be a power of two.
module sky_fetch_buffer
    import sky_xu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           push_entry,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t         mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_push   = push && !clear;
    assign do_pop    = pop && !clear && (occupancy != '0);
    assign head      = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            occupancy <= occupancy + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define
    // which entries are meaningful, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/sky_fetch_stage.sv
// XU instruction fetch stage: sequential PC requests, in-order response buffering,
// one instruction (or NOP bubble) per unstalled cycle, redirect flush.
// Optional SKY_FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module sky_fetch_stage
    import sky_xu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    sky_fetch_stage_if.master  imem,
    output logic [31:0]        pc_out,
    output logic [31:0]        instruction,
    output logic               instr_valid
`ifdef SKY_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(BUF_DEPTH);

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_next;
    logic [CW-1:0] occupancy;
    logic          req_fire;
    logic          resp_keep;
    logic          pop;
    fetch_entry_t  head;

    // Reserving a slot per outstanding request guarantees every response fits.
    assign imem.imem_req_valid = (state == RUN) && !redirect &&
                                 (((CW+1)'(occupancy) + (CW+1)'(outstanding)) < DEPTH_LIM);
    assign imem.imem_req_addr  = fetch_pc;

    assign req_fire         = imem.imem_req_valid && imem.imem_req_ready;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem.imem_resp_valid);
    assign resp_keep        = imem.imem_resp_valid && (state == RUN) && !redirect;
    assign pop              = !stall && !redirect && (occupancy != '0);

    sky_fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (resp_keep),
        .pop        (pop),
        .clear      (redirect),
        .push_entry ('{pc: 32'(fetch_pc - 32'd4 * 32'(outstanding)), insn: imem.imem_resp_data}),
        .head       (head),
        .occupancy  (occupancy)
    );

    // NOTE: every variable written here gets a default first, so no path through the
    // case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        drop_cnt_next = drop_cnt;
        case (state)
            IDLE:  state_next = RUN;
            RUN:   state_next = RUN;
            FLUSH: begin
                if (imem.imem_resp_valid) drop_cnt_next = drop_cnt - CW'(1);
                if (drop_cnt_next == '0)  state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            drop_cnt_next = outstanding_next;
            state_next    = (outstanding_next != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            if (redirect)      fetch_pc <= redirect_pc & ~32'h3;
            else if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Decode-facing register: redirect wins over stall and forces a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out      <= '0;
            instruction <= NOP_INSN;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            instruction <= NOP_INSN;
            instr_valid <= 1'b0;
        end else if (!stall) begin
            if (pop) begin
                pc_out      <= head.pc;
                instruction <= head.insn;
                instr_valid <= 1'b1;
            end else begin
                instruction <= NOP_INSN;
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef SKY_FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else if (!stall) begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            else     perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sky_fetch_stage.sv
// Self-checking bench for sky_fetch_stage: directed cycle table, hand-written corner
// sequences, then randomized traffic against an in-order memory and a PC-stream model.
module tb_sky_fetch_stage;
    import sky_xu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] w_pc_out;
    logic [31:0] w_instruction;
    logic        w_instr_valid;
`ifdef SKY_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles, w_perf_fetched, w_perf_bubbles;
`endif

    always #5 clk = ~clk;

    sky_fetch_stage_if imem ();
    sky_fetch_stage_if wmem ();

    sky_fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(imem), .pc_out(pc_out),
        .instruction(instruction), .instr_valid(instr_valid)
`ifdef SKY_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    sky_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem(wmem), .pc_out(w_pc_out),
        .instruction(w_instruction), .instr_valid(w_instr_valid)
`ifdef SKY_FETCH_PERF_EN
        , .perf_fetched(w_perf_fetched), .perf_bubbles(w_perf_bubbles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h13;
    endfunction

    // In-order memory: each accepted request answers `lat` cycles later, never reordered.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    cyc = 0;
    int    lat = 1;
    int    last_due = -1;

    // Reference model: the decode stream is the PC sequence from the latest redirect.
    logic [31:0] exp_fetch, exp_deliver;
    int          epoch_issued, epoch_delivered, delivered_total;
    logic        prev_stall, prev_redirect, prev_valid, prev_req_pend;
    logic [31:0] prev_pc, prev_insn, prev_req_addr;
    logic        last_req_valid;
    logic [31:0] last_req_addr;
    logic        w_acc_prev;
    logic [31:0] w_addrs[$];

    task automatic observe();
        if (prev_redirect) begin
            check_b("redirect_bubble_valid", instr_valid, 1'b0);
            check("redirect_bubble_insn", instruction, NOP_INSN);
        end else if (prev_stall) begin
            check("stall_hold_pc", pc_out, prev_pc);
            check("stall_hold_insn", instruction, prev_insn);
            check_b("stall_hold_valid", instr_valid, prev_valid);
        end else if (instr_valid) begin
            check("deliver_pc", pc_out, exp_deliver);
            check("deliver_insn", instruction, insn_of(exp_deliver));
            exp_deliver += 32'd4;
            epoch_delivered++;
            delivered_total++;
        end else begin
            check("bubble_insn", instruction, NOP_INSN);
            check("bubble_pc_hold", pc_out, prev_pc);
        end
        prev_pc    = pc_out;
        prev_insn  = instruction;
        prev_valid = instr_valid;
    endtask

    task automatic drive_cycle(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
        int due;
        stall                = s;
        redirect             = r;
        redirect_pc          = rp;
        imem.imem_req_ready  = rdy;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem.imem_resp_valid = 1'b1;
            imem.imem_resp_data  = insn_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem.imem_resp_valid = 1'b0;
            imem.imem_resp_data  = $urandom;
        end
        wmem.imem_req_ready  = 1'b1;
        wmem.imem_resp_valid = w_acc_prev;
        wmem.imem_resp_data  = 32'h1234_5678;
        #1;
        if (r) begin
            check_b("no_req_on_redirect", imem.imem_req_valid, 1'b0);
        end else if (prev_req_pend) begin
            check_b("req_hold_valid", imem.imem_req_valid, 1'b1);
            check("req_hold_addr", imem.imem_req_addr, prev_req_addr);
        end
        last_req_valid = imem.imem_req_valid;
        last_req_addr  = imem.imem_req_addr;
        if (imem.imem_req_valid && rdy) begin
            check("req_addr", imem.imem_req_addr, exp_fetch);
            exp_fetch += 32'd4;
            epoch_issued++;
            check_b("inflight_bound", (epoch_issued - epoch_delivered) <= 2, 1'b1);
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: imem.imem_req_addr, due: due});
            last_due = due;
        end
        prev_req_pend = imem.imem_req_valid && !rdy;
        prev_req_addr = imem.imem_req_addr;
        w_acc_prev    = wmem.imem_req_valid;
        if (wmem.imem_req_valid) w_addrs.push_back(wmem.imem_req_addr);
        if (r) begin
            exp_fetch       = rp & ~32'h3;
            exp_deliver     = rp & ~32'h3;
            epoch_issued    = 0;
            epoch_delivered = 0;
        end
        prev_stall    = s;
        prev_redirect = r;
        cyc++;
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        observe();
        drive_cycle(s, r, rp, rdy);
    endtask

    typedef struct {
        logic        req_valid;
        logic [31:0] req_addr;
        logic        instr_valid;
        logic [31:0] pc_out;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int   found;
        int   start_del;
        logic [31:0] rp;
`ifdef SKY_FETCH_PERF_EN
        logic [31:0] pb_prev;
`endif
        // Unstalled, ready=1, 1-cycle memory from reset release (row 0 = IDLE cycle).
        tbl[0] = '{1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h0,  1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'h4,  1'b0, 32'h0};
        tbl[3] = '{1'b0, 32'h0,  1'b0, 32'h0};
        tbl[4] = '{1'b1, 32'h8,  1'b1, 32'h0};
        tbl[5] = '{1'b1, 32'hC,  1'b1, 32'h4};
        tbl[6] = '{1'b0, 32'h0,  1'b0, 32'h4};
        tbl[7] = '{1'b1, 32'h10, 1'b1, 32'h8};

        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem.imem_req_ready = 1'b0; imem.imem_resp_valid = 1'b0; imem.imem_resp_data = '0;
        wmem.imem_req_ready = 1'b0; wmem.imem_resp_valid = 1'b0; wmem.imem_resp_data = '0;
        exp_fetch = 32'h0; exp_deliver = 32'h0;
        epoch_issued = 0; epoch_delivered = 0; delivered_total = 0;
        prev_stall = 1'b0; prev_redirect = 1'b0; prev_valid = 1'b0; prev_req_pend = 1'b0;
        prev_pc = '0; prev_insn = NOP_INSN; prev_req_addr = '0; w_acc_prev = 1'b0;
        last_req_valid = 1'b0; last_req_addr = '0;

        repeat (3) @(negedge clk);
        check("reset_pc_out", pc_out, 32'h0);
        check("reset_insn", instruction, NOP_INSN);
        check_b("reset_valid", instr_valid, 1'b0);
        check_b("reset_req_valid", imem.imem_req_valid, 1'b0);

        // Test 1: cycle table from reset release.
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            else reset_n = 1'b1;
            check_b("tbl_instr_valid", instr_valid, tbl[i].instr_valid);
            check("tbl_pc_out", pc_out, tbl[i].pc_out);
            observe();
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check_b("tbl_req_valid", last_req_valid, tbl[i].req_valid);
            if (tbl[i].req_valid) check("tbl_req_addr", last_req_addr, tbl[i].req_addr);
        end

        // Test 2: five stalled cycles; requests stop once the buffer is reserved full.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_b("stall_req_blocked", last_req_valid, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Test 3: redirect to 0x100 with two requests in flight.
        lat = 3;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (mq.size() == 2) found = 1;
        end
        check("t3_two_outstanding", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (instr_valid && !prev_redirect) begin
                found = 1;
                check("t3_first_pc", pc_out, 32'h100);
            end
            observe();
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check("t3_refetch_seen", 32'(found), 32'd1);

        // Test 4: redirect together with stall still forces a bubble.
        lat = 1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            observe();
            if (instr_valid) begin
                found = 1;
                drive_cycle(1'b1, 1'b1, 32'h200, 1'b1);
            end else begin
                drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
            end
        end
        check("t4_valid_seen", 32'(found), 32'd1);
        @(negedge clk);
        check("t4_nop", instruction, NOP_INSN);
        check_b("t4_valid", instr_valid, 1'b0);
        observe();
        drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Test 6: memory not ready for three cycles right after a clean redirect.
        for (int k = 0; k < 20 && mq.size() != 0; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_drained", 32'(mq.size()), 32'd0);
        step(1'b0, 1'b1, 32'h300, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            observe();
            check_b("t6_bubble", instr_valid, 1'b0);
`ifdef SKY_FETCH_PERF_EN
            if (k > 0) check("t6_perf_bubbles", perf_bubbles, pb_prev + 32'd1);
            pb_prev = perf_bubbles;
`endif
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
            check_b("t6_req_valid", last_req_valid, 1'b1);
            check("t6_req_addr", last_req_addr, 32'h300);
        end
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Test 5: second instance starting near the top of the address space.
        check_b("wrap_req_count", w_addrs.size() >= 3, 1'b1);
        if (w_addrs.size() >= 3) begin
            check("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
            check("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
            check("wrap_addr2", w_addrs[2], 32'h0000_0000);
        end

        // Randomized traffic: stalls, redirects (some near wrap, unaligned), backpressure.
        start_del = delivered_total;
        for (int k = 0; k < 800; k++) begin
            lat = $urandom_range(1, 4);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0, rp,
                 $urandom_range(0, 9) < 7);
        end
        check_b("random_progress", (delivered_total - start_del) > 50, 1'b1);

        // Asynchronous reset mid-cycle clears outputs without waiting for a clock edge.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_pc", pc_out, 32'h0);
        check("async_reset_insn", instruction, NOP_INSN);
        check_b("async_reset_valid", instr_valid, 1'b0);
        check_b("async_reset_req", imem.imem_req_valid, 1'b0);
        mq.delete();
        imem.imem_resp_valid = 1'b0;
        wmem.imem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
